// File: rtl/mc_bus_master.sv
// mc_bus_master: initiator for the 16-bit asynchronous memory-controller register bus.
// Turns single read/write commands into ce/oe/we bus cycles with programmable
// address-setup, data-strobe and hold timing. Every bus output is a flop.
//
// Command handshake: a command transfers on a rising clock edge where both
// cmd_valid and cmd_ready are high. cmd_ready is high only in IDLE, so cmd_*
// are ignored while a bus cycle is in progress and nothing is queued.
// rsp_valid is a single-cycle pulse with no back-pressure.
module mc_bus_master #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int ADDSET_CYCLES = 2,
    parameter int DATAST_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [MC_ADD_WIDTH-1:0]  cmd_addr,
    input  logic [MC_DATA_WIDTH-1:0] cmd_wdata,
    output logic                     rsp_valid,
    output logic [MC_DATA_WIDTH-1:0] rsp_rdata,
    output logic                     busy,
    output logic                     mc_ce,
    output logic                     mc_oe,
    output logic                     mc_we,
    output logic [MC_ADD_WIDTH-1:0]  mc_add,
    output logic [MC_DATA_WIDTH-1:0] mc_data_out,
    output logic                     mc_data_oe,
    input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDSET = 2'd1,
        ST_DATAST = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                   state_q;
    logic [7:0]               cnt_q;
    logic                     write_q;
    logic                     cmd_ready_q;
    logic                     rsp_valid_q;
    logic [MC_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                     busy_q;
    logic                     mc_ce_q;
    logic                     mc_oe_q;
    logic                     mc_we_q;
    logic [MC_ADD_WIDTH-1:0]  mc_add_q;
    logic [MC_DATA_WIDTH-1:0] mc_data_out_q;
    logic                     mc_data_oe_q;

    // Phase lengths minus one: the counter is loaded on phase entry and the
    // phase ends on the cycle it reads zero.
    localparam logic [7:0] ADDSET_LOAD = 8'(ADDSET_CYCLES - 1);
    localparam logic [7:0] DATAST_LOAD = 8'(DATAST_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    // Bus-cycle sequencer; every bus and handshake output is set here so the
    // pads only ever see flop outputs. Reset forces strobes inactive at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            write_q       <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            busy_q        <= 1'b0;
            mc_ce_q       <= 1'b1;
            mc_oe_q       <= 1'b1;
            mc_we_q       <= 1'b1;
            mc_add_q      <= '0;
            mc_data_out_q <= '0;
            mc_data_oe_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        state_q      <= ST_ADDSET;
                        cnt_q        <= ADDSET_LOAD;
                        write_q      <= cmd_write;
                        cmd_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        mc_ce_q      <= 1'b0;
                        mc_add_q     <= cmd_addr;
                        mc_data_oe_q <= cmd_write;
                        if (cmd_write) begin
                            mc_data_out_q <= cmd_wdata;
                        end
                    end
                end
                ST_ADDSET: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_DATAST;
                        cnt_q   <= DATAST_LOAD;
                        if (write_q) begin
                            mc_we_q <= 1'b0;
                        end else begin
                            mc_oe_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_DATAST: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_LOAD;
                        mc_oe_q <= 1'b1;
                        mc_we_q <= 1'b1;
                        // Read data is taken while oe is still low on the bus.
                        if (!write_q) begin
                            rsp_rdata_q <= mc_data_in;
                            rsp_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_q      <= ST_IDLE;
                        cmd_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        mc_ce_q      <= 1'b1;
                        mc_data_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = busy_q;
    assign mc_ce       = mc_ce_q;
    assign mc_oe       = mc_oe_q;
    assign mc_we       = mc_we_q;
    assign mc_add      = mc_add_q;
    assign mc_data_out = mc_data_out_q;
    assign mc_data_oe  = mc_data_oe_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mc_bus_master.sv
// Directed bench for mc_bus_master with a small register-file responder.
module tb_mc_bus_master;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        mc_ce;
  logic        mc_oe;
  logic        mc_we;
  logic [5:0]  mc_add;
  logic [15:0] mc_data_out;
  logic        mc_data_oe;
  logic [15:0] mc_data_in;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // responder controls
  logic        loop_en;
  logic [15:0] data_in_drv;
  logic [15:0] mem [0:63];

  mc_bus_master dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .mc_ce       (mc_ce),
    .mc_oe       (mc_oe),
    .mc_we       (mc_we),
    .mc_add      (mc_add),
    .mc_data_out (mc_data_out),
    .mc_data_oe  (mc_data_oe),
    .mc_data_in  (mc_data_in),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // responder: stores on we low, returns data only while oe is low
  always @(posedge clock) begin
    if (!mc_ce && !mc_we) mem[mc_add] <= mc_data_out;
  end
  assign mc_data_in = !mc_oe ? (loop_en ? mem[mc_add] : data_in_drv) : 16'hBEEF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // wait for the accepting edge; returns just after it
  task automatic wait_accept(output int acc_cyc, output int idle_cnt);
    logic rdy;
    int   got;
    got = 0;
    idle_cnt = 0;
    for (int n = 0; n < 50 && got == 0; n++) begin
      @(negedge clock);
      if (mc_ce) idle_cnt++;
      rdy = cmd_ready;
      @(posedge clock);
      if (rdy && cmd_valid) got = 1;
    end
    #1;
    acc_cyc = cyc;
    check_eq("accept", got, 1);
  endtask

  task automatic issue(input logic wr, input logic [5:0] a, input logic [15:0] d);
    int ac, ic;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    wait_accept(ac, ic);
    cmd_valid = 1'b0;
    cmd_wdata = 16'hFFFF;
    cmd_addr  = 6'h3F;
  endtask

  // cycles k=1..9 after accept: 1-2 setup, 3-6 strobe, 7-8 hold, 9 idle
  task automatic check_write_cycles(input logic [5:0] a, input logic [15:0] d);
    logic in_tx, strb;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      in_tx = (k <= 8);
      strb  = (k >= 3 && k <= 6);
      check_eq($sformatf("wr_ce_k%0d", k), mc_ce, !in_tx);
      check_eq($sformatf("wr_we_k%0d", k), mc_we, !strb);
      check_eq($sformatf("wr_oe_k%0d", k), mc_oe, 1);
      check_eq($sformatf("wr_doe_k%0d", k), mc_data_oe, in_tx);
      check_eq($sformatf("wr_rspv_k%0d", k), rsp_valid, 0);
      check_eq($sformatf("wr_busy_k%0d", k), busy, in_tx);
      check_eq($sformatf("wr_rdy_k%0d", k), cmd_ready, !in_tx);
      if (in_tx) begin
        check_eq($sformatf("wr_add_k%0d", k), mc_add, a);
        check_eq($sformatf("wr_dout_k%0d", k), mc_data_out, d);
      end
    end
  endtask

  task automatic check_read_cycles(input logic [5:0] a, input logic [15:0] d);
    logic in_tx, strb;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      in_tx = (k <= 8);
      strb  = (k >= 3 && k <= 6);
      check_eq($sformatf("rd_ce_k%0d", k), mc_ce, !in_tx);
      check_eq($sformatf("rd_oe_k%0d", k), mc_oe, !strb);
      check_eq($sformatf("rd_we_k%0d", k), mc_we, 1);
      check_eq($sformatf("rd_doe_k%0d", k), mc_data_oe, 0);
      check_eq($sformatf("rd_rspv_k%0d", k), rsp_valid, (k == 7));
      if (in_tx) check_eq($sformatf("rd_add_k%0d", k), mc_add, a);
      if (k >= 7) check_eq($sformatf("rd_data_k%0d", k), rsp_rdata, d);
    end
  endtask

  initial begin
    int a1, a2, ic, ce_low;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    loop_en     = 1'b0;
    data_in_drv = 16'h0000;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    // 1: reset values
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_ce", mc_ce, 1);
    check_eq("rst_oe", mc_oe, 1);
    check_eq("rst_we", mc_we, 1);
    check_eq("rst_doe", mc_data_oe, 0);
    check_eq("rst_rspv", rsp_valid, 0);
    check_eq("rst_rdata", rsp_rdata, 16'h0000);
    check_eq("rst_add", mc_add, 6'h00);
    check_eq("rst_dout", mc_data_out, 16'h0000);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rel_rdy", cmd_ready, 1);
    check_eq("rel_state", dbg_state, 2'd0);

    // 2: write 0x19 <- A5C3
    @(posedge clock); #1;
    issue(1'b1, 6'h19, 16'hA5C3);
    check_write_cycles(6'h19, 16'hA5C3);

    // 3: read 0x10 returns 00F0, held through a following write
    data_in_drv = 16'h00F0;
    @(posedge clock); #1;
    issue(1'b0, 6'h10, 16'h0000);
    check_read_cycles(6'h10, 16'h00F0);
    data_in_drv = 16'h7777;
    @(posedge clock); #1;
    issue(1'b1, 6'h2A, 16'h5555);
    check_write_cycles(6'h2A, 16'h5555);
    check_eq("rdata_held", rsp_rdata, 16'h00F0);

    // 4: back-to-back writes with cmd_valid held high
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 6'h05;
    cmd_wdata = 16'h1111;
    wait_accept(a1, ic);
    cmd_addr  = 6'h06;
    cmd_wdata = 16'h2222;
    ce_low = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (!mc_ce) ce_low++;
      if (k == 2) begin
        check_eq("b2b_first_dout", mc_data_out, 16'h1111);
        check_eq("b2b_first_add", mc_add, 6'h05);
      end
    end
    check_eq("b2b_ce_low", ce_low, 8);
    wait_accept(a2, ic);
    cmd_valid = 1'b0;
    check_eq("b2b_period", a2 - a1, 9);
    check_eq("b2b_ce_high", ic, 1);
    check_write_cycles(6'h06, 16'h2222);

    // 5: reset during 2nd strobe cycle of a read
    data_in_drv = 16'h00F0;
    @(posedge clock); #1;
    issue(1'b0, 6'h10, 16'h0000);
    repeat (3) @(negedge clock);
    @(posedge clock); #2;
    check_eq("pre_rst_oe", mc_oe, 0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_oe", mc_oe, 1);
    check_eq("mid_rst_ce", mc_ce, 1);
    check_eq("mid_rst_we", mc_we, 1);
    check_eq("mid_rst_doe", mc_data_oe, 0);
    check_eq("mid_rst_busy", busy, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check_eq("mid_rst_rspv", rsp_valid, 0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_eq("post_rst_rspv", rsp_valid, 0);
      check_eq("post_rst_ce", mc_ce, 1);
    end
    check_eq("post_rst_rdata", rsp_rdata, 16'h0000);
    data_in_drv = 16'h3C3C;
    @(posedge clock); #1;
    issue(1'b0, 6'h10, 16'h0000);
    check_read_cycles(6'h10, 16'h3C3C);

    // 6: loopback write then read
    loop_en = 1'b1;
    @(posedge clock); #1;
    issue(1'b1, 6'h19, 16'h1234);
    check_write_cycles(6'h19, 16'h1234);
    @(posedge clock); #1;
    issue(1'b0, 6'h19, 16'h0000);
    check_read_cycles(6'h19, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
